hack_memory: RTL and testbench
==============================

# hack_memory

Data-memory stage of the Hack platform: the unit that consumes the four load strobes produced by `dmux4way` and owns the storage they select. It decodes the CPU's 15-bit address into RAM, screen, and keyboard regions, and performs writes on the clock edge. It returns read data combinationally, as the Hack CPU requires. It also provides a registered read port for the display scanner and a latched keyboard register.

## Interface
Parameters:
- `DATA_W`, 16: word width.
- `ADDR_W`, 15: CPU address width.
- `RAM_WORDS`, 16384: general RAM depth, covering 0x0000–0x3FFF.
- `SCR_WORDS`, 8192: screen buffer depth, covering 0x4000–0x5FFF.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in` input 16: CPU write data.
- `load` input 1: CPU write enable.
- `address` input 15: CPU address.
- `out` output 16: CPU read data (combinational).
- `kbd_code` input 16: scan code from the keyboard interface.
- `kbd_valid` input 1: when high, `kbd_code` is captured into the keyboard register.
- `scr_addr` input 13: display-scanner read address.
- `scr_data` output 16: display-scanner read data (registered).

## Operation
- Region decode uses `sel = address[14:13]`, feeding a `dmux4way` that splits `load` into `ld_a`..`ld_d`:
  - `ld_a` or `ld_b` (sel 00/01) writes RAM at `address[13:0]`.
  - `ld_c` (sel 10) writes the screen at `address[12:0]`.
  - `ld_d` (sel 11) writes nothing: the keyboard is read-only and all other addresses are unmapped.
- CPU read mux for `out`:
  - RAM region returns the RAM word.
  - Screen region returns the screen word.
  - `address == 15'h6000` returns `kbd_reg`.
  - Any address in 0x6001–0x7FFF returns 16'h0000.
- Keyboard register: `kbd_reg <= kbd_code` on every edge where `kbd_valid` is high; otherwise it holds. A key release is delivered as `kbd_valid` with code 0.
- Display port: `scr_data <= screen[scr_addr]` on every edge. This is an independent second read port of the screen array.
- RAM and screen arrays are not cleared by `reset`. Their contents are undefined until written.

## Timing
- Reset values:
  - `kbd_reg` = 0, so `out` = 0 when address is 0x6000.
  - `scr_data` = 0.
  - `out` otherwise reflects the array contents.
- While `reset` is high, all writes are suppressed. This applies to RAM, screen, and the keyboard capture.
- `reset` asserted mid-write: the write in that cycle is dropped.
- Write latency: data written at edge N is visible on `out` from just after edge N. Before the edge, `out` shows the old word, so a read and a write to the same address in one cycle returns the old value.
- Display read latency: one cycle. If a CPU write and a scanner read hit the same screen word at the same edge, `scr_data` returns the old word. The new word is visible one edge later.
- A CPU `load` to 0x6000 while `kbd_valid` is high: `kbd_reg` takes `kbd_code`, and the CPU write is ignored.
- Address wrap: none. Every 15-bit value decodes to exactly one of RAM, screen, keyboard, or unmapped.

## Structure
- Package `hack_mem_pkg` holds:
  - constants `RAM_BASE` = 15'h0000, `SCR_BASE` = 15'h4000, `KBD_ADDR` = 15'h6000;
  - typedef `region_t` with values `REG_RAM`, `REG_SCR`, `REG_KBD`, `REG_NONE`;
  - typedef `word_t` = logic [15:0].
- Sub-module: the existing `dmux4way`, instantiated once for load routing. Arrays are inferred inline; no further hierarchy.

## Test plan
- Reset, then read 0x6000 → `out` = 0x0000, and `scr_data` = 0x0000 after the next edge.
- Write 0x1234 to 0x0000 and 0xBEEF to 0x3FFF, then read both → `out` = 0x1234 and 0xBEEF; reading 0x4000 does not return either value.
- Write 0xAAAA to 0x4005, then set `scr_addr` = 5 → `scr_data` = 0xAAAA one edge later. In the same cycle as a second write of 0x5555 to 0x4005, `scr_data` still reads 0xAAAA, and reads 0x5555 one edge after that.
- `kbd_valid` = 1 with `kbd_code` = 0x0041, and simultaneously a CPU write of 0xFFFF to 0x6000 → `out` at 0x6000 = 0x0041. Then `kbd_valid` with code 0 → `out` = 0x0000.
- Write 0x7777 to 0x6001 and to 0x7FFF → both read back 0x0000, and RAM location 0x2001 and screen location 0x4001 are unchanged.
- Assert `reset` during a write of 0x9999 to 0x0010 that follows an earlier write of 0x1111 → a read of 0x0010 returns 0x1111.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory stage.
//   RAM_BASE / SCR_BASE / KBD_ADDR : CPU memory-map anchors
//   region_t                       : which region a CPU address falls in
//   word_t                         : Hack machine word
//   decode_region()                : classify a 15-bit CPU address
package hack_mem_pkg;

    localparam logic [14:0] RAM_BASE = 15'h0000;
    localparam logic [14:0] SCR_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    typedef logic [15:0] word_t;

    // Every 15-bit value lands in exactly one region; nothing wraps.
    function automatic region_t decode_region(input logic [14:0] a);
        region_t r;
        if (a >= RAM_BASE && a < SCR_BASE) begin
            r = REG_RAM;
        end else if (a < KBD_ADDR) begin
            r = REG_SCR;
        end else if (a == KBD_ADDR) begin
            r = REG_KBD;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_memory_dmux4way.sv
// 1-to-4 demultiplexer: routes i_in to the output chosen by i_sel.
//   i_in  : bit to route
//   i_sel : 00->o_a, 01->o_b, 10->o_c, 11->o_d
//   o_a..o_d : routed copies, zero when not selected
module dmux4way (
    input  logic       i_in,
    input  logic [1:0] i_sel,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d
);

    assign o_a = i_in & (i_sel == 2'b00);
    assign o_b = i_in & (i_sel == 2'b01);
    assign o_c = i_in & (i_sel == 2'b10);
    assign o_d = i_in & (i_sel == 2'b11);

endmodule

// File: rtl/hack_memory.sv
// Hack data-memory stage: general RAM, screen buffer and keyboard register.
//   clk, reset          : clock, synchronous active-high reset
//   in, load, address   : CPU write data, write enable, address
//   out                 : CPU read data, combinational
//   kbd_code, kbd_valid : keyboard scan code and capture strobe
//   scr_addr, scr_data  : display-scanner read address and registered data
module hack_memory
    import hack_mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int RAM_WORDS = 16384,
    parameter int SCR_WORDS = 8192
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            in,
    input  logic                         load,
    input  logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            out,
    input  logic [DATA_W-1:0]            kbd_code,
    input  logic                         kbd_valid,
    input  logic [$clog2(SCR_WORDS)-1:0] scr_addr,
    output logic [DATA_W-1:0]            scr_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);

    logic [DATA_W-1:0] r_ram [RAM_WORDS];
    logic [DATA_W-1:0] r_scr [SCR_WORDS];
    logic [DATA_W-1:0] r_kbd;
    logic [DATA_W-1:0] r_scr_data;

    logic              w_ld_a;
    logic              w_ld_b;
    logic              w_ld_c;
    // Strobe for the keyboard/unmapped quadrant: such writes are dropped.
    logic              w_ld_d_unused;
    logic              w_ram_we;
    logic              w_scr_we;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_idx;
    region_t           w_region;

    dmux4way u_dmux (
        .i_in  (load),
        .i_sel (address[14:13]),
        .o_a   (w_ld_a),
        .o_b   (w_ld_b),
        .o_c   (w_ld_c),
        .o_d   (w_ld_d_unused)
    );

    assign w_ram_idx = address[RAM_AW-1:0];
    assign w_scr_idx = address[SCR_AW-1:0];
    assign w_ram_we  = (w_ld_a | w_ld_b) & ~reset;
    assign w_scr_we  = w_ld_c & ~reset;
    assign w_region  = decode_region(address);

    // Arrays carry no reset; reset only blocks the write enable.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= in;
        end
        if (w_scr_we) begin
            r_scr[w_scr_idx] <= in;
        end
    end

    // Scanner port reads the pre-edge word, so a same-edge CPU write
    // shows up one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd      <= '0;
            r_scr_data <= '0;
        end else begin
            r_scr_data <= r_scr[scr_addr];
            if (kbd_valid) begin
                r_kbd <= kbd_code;
            end
        end
    end

    always_comb begin
        out = '0;
        case (w_region)
            REG_RAM:  out = r_ram[w_ram_idx];
            REG_SCR:  out = r_scr[w_scr_idx];
            REG_KBD:  out = r_kbd;
            default:  out = '0;
        endcase
    end

    assign scr_data = r_scr_data;

endmodule

// File: tb/tb_hack_memory.sv
module tb_hack_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [14:0] address;
    logic [15:0] out;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;

    int total = 0;
    int bad   = 0;

    hack_memory dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .address   (address),
        .out       (out),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: sparse arrays hold only words actually written.
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kbd_m = 16'h0;
    logic [15:0] exp_scr = 16'h0;
    bit          exp_scr_known = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            kbd_m = 16'h0;
            exp_scr = 16'h0;
            exp_scr_known = 1;
        end else begin
            exp_scr_known = scr_m.exists(int'(scr_addr));
            if (exp_scr_known) exp_scr = scr_m[int'(scr_addr)];
            if (kbd_valid) kbd_m = kbd_code;
            if (load) begin
                if (int'(address) < 'h4000)      ram_m[int'(address)] = in;
                else if (int'(address) < 'h6000) scr_m[int'(address) - 'h4000] = in;
            end
        end
    end

    function automatic bit model_out(input logic [14:0] a, output logic [15:0] v);
        int ai = int'(a);
        v = 16'h0;
        if (ai < 'h4000) begin
            if (!ram_m.exists(ai)) return 0;
            v = ram_m[ai];
        end else if (ai < 'h6000) begin
            if (!scr_m.exists(ai - 'h4000)) return 0;
            v = scr_m[ai - 'h4000];
        end else if (ai == 'h6000) begin
            v = kbd_m;
        end
        return 1;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [15:0] ev;
        if (chk_en) begin
            if (model_out(address, ev)) check("out_model", out, ev);
            if (exp_scr_known) check("scr_data_model", scr_data, exp_scr);
        end
    end

    task automatic drive(input bit rst, input bit ld, input logic [14:0] a, input logic [15:0] d,
                         input bit kv, input logic [15:0] kc, input logic [12:0] sa);
        reset = rst; load = ld; address = a; in = d;
        kbd_valid = kv; kbd_code = kc; scr_addr = sa;
    endtask

    task automatic step(input bit rst, input bit ld, input logic [14:0] a, input logic [15:0] d,
                        input bit kv, input logic [15:0] kc, input logic [12:0] sa);
        drive(rst, ld, a, d, kv, kc, sa);
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        step(0, 1, a, d, 0, 16'h0, scr_addr);
    endtask

    task automatic rd_check(input string name, input logic [14:0] a, input logic [15:0] exp);
        load = 0; kbd_valid = 0; address = a;
        #1;
        check(name, out, exp);
    endtask

    function automatic logic [14:0] pick_addr();
        logic [14:0] base;
        case ($urandom_range(0, 5))
            0: base = 15'h0000;
            1: base = 15'h3FF8;
            2: base = 15'h4000;
            3: base = 15'h5FF8;
            4: return 15'h6000;
            default: return ($urandom_range(0, 1) != 0) ? 15'h6001 : 15'h7FFF;
        endcase
        return base + 15'($urandom_range(0, 7));
    endfunction

    initial begin
        drive(1, 0, 15'h0, 16'h0, 0, 16'h0, 13'h0);
        #2;
        step(1, 0, 15'h0, 16'h0, 0, 16'h0, 13'h0);
        step(1, 0, 15'h0, 16'h0, 0, 16'h0, 13'h0);
        chk_en = 1;
        check("scr_data_reset", scr_data, 16'h0000);
        step(0, 0, 15'h6000, 16'h0, 0, 16'h0, 13'h0);
        rd_check("kbd_reset", 15'h6000, 16'h0000);

        wr(15'h0000, 16'h1234);
        wr(15'h3FFF, 16'hBEEF);
        wr(15'h4000, 16'h0F0F);
        rd_check("ram_lo", 15'h0000, 16'h1234);
        rd_check("ram_hi", 15'h3FFF, 16'hBEEF);
        rd_check("scr_base_distinct", 15'h4000, 16'h0F0F);

        step(0, 1, 15'h4005, 16'hAAAA, 0, 16'h0, 13'h0);
        step(0, 0, 15'h4005, 16'h0, 0, 16'h0, 13'h5);
        check("scr_port_first", scr_data, 16'hAAAA);
        step(0, 1, 15'h4005, 16'h5555, 0, 16'h0, 13'h5);
        check("scr_port_same_edge_old", scr_data, 16'hAAAA);
        step(0, 0, 15'h4005, 16'h0, 0, 16'h0, 13'h5);
        check("scr_port_new", scr_data, 16'h5555);

        step(0, 1, 15'h6000, 16'hFFFF, 1, 16'h0041, 13'h5);
        rd_check("kbd_capture", 15'h6000, 16'h0041);
        step(0, 0, 15'h6000, 16'h0, 1, 16'h0000, 13'h5);
        rd_check("kbd_release", 15'h6000, 16'h0000);

        wr(15'h2001, 16'h1357);
        wr(15'h4001, 16'h2468);
        wr(15'h6001, 16'h7777);
        wr(15'h7FFF, 16'h7777);
        rd_check("unmapped_6001", 15'h6001, 16'h0000);
        rd_check("unmapped_7fff", 15'h7FFF, 16'h0000);
        rd_check("ram_2001_kept", 15'h2001, 16'h1357);
        rd_check("scr_4001_kept", 15'h4001, 16'h2468);

        wr(15'h0010, 16'h1111);
        step(1, 1, 15'h0010, 16'h9999, 1, 16'h00AB, 13'h5);
        check("scr_data_in_reset", scr_data, 16'h0000);
        step(0, 0, 15'h0010, 16'h0, 0, 16'h0, 13'h5);
        rd_check("reset_drops_write", 15'h0010, 16'h1111);
        rd_check("reset_drops_kbd", 15'h6000, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            logic [12:0] sa;
            sa = ($urandom_range(0, 1) != 0) ? 13'($urandom_range(0, 7))
                                              : 13'h1FF8 + 13'($urandom_range(0, 7));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) != 0), pick_addr(),
                 16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom), sa);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
